// File: rtl/bus_demux_1x2.sv
// -----------------------------------------------------------------------------
// bus_demux_1x2
//
// Routes a single data-memory request from the core to either RAM (port 0)
// or MMIO (port 1), chosen by comparing the request address against
// SPLIT_ADDR. Only one transaction is outstanding at a time. The selected
// target's response is returned to the core through a 2:1 mux steered by the
// latched select. A target that never acknowledges is closed with an error
// response after TIMEOUT cycles of held request.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   m_req/m_we         core request valid / store(1) or load(0)
//   m_addr/m_wdata     core request address / store data
//   m_ready            high while idle and able to accept a request
//   m_rvalid           one-cycle response strobe
//   m_rdata/m_err      load data (0 for stores and errors) / timeout flag,
//                      held after the strobe until the next response
//   s0_* / s1_*        target request channels (req/we/addr/wdata out,
//                      ack/rdata in); req held until ack or timeout
// -----------------------------------------------------------------------------
module bus_demux_1x2 #(
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter logic [AW-1:0] SPLIT_ADDR = AW'(32'h8000_0000),
    parameter int            TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m_req,
    input  logic          m_we,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_wdata,
    output logic          m_ready,
    output logic          m_rvalid,
    output logic [DW-1:0] m_rdata,
    output logic          m_err,

    output logic          s0_req,
    output logic          s0_we,
    output logic [AW-1:0] s0_addr,
    output logic [DW-1:0] s0_wdata,
    input  logic          s0_ack,
    input  logic [DW-1:0] s0_rdata,

    output logic          s1_req,
    output logic          s1_we,
    output logic [AW-1:0] s1_addr,
    output logic [DW-1:0] s1_wdata,
    input  logic          s1_ack,
    input  logic [DW-1:0] s1_rdata
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic            sel_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;

    logic            selAck;
    logic [DW-1:0]   selRdata;

    // Return path: the latched select picks which target's ack/rdata the
    // FSM listens to, so an ack from the other port can never complete
    // the transaction.
    always_comb begin
        selAck   = 1'b0;
        selRdata = '0;
        if (sel_q) begin
            selAck   = s1_ack;
            selRdata = s1_rdata;
        end else begin
            selAck   = s0_ack;
            selRdata = s0_rdata;
        end
    end

    // Transaction FSM. Acks are only looked at in BUSY; new requests only
    // in IDLE. An ack on the final BUSY cycle takes priority over timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_req) begin
                        we_q    <= m_we;
                        addr_q  <= m_addr;
                        wdata_q <= m_wdata;
                        sel_q   <= (m_addr >= SPLIT_ADDR);
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (selAck) begin
                        rdata_q <= we_q ? '0 : selRdata;
                        err_q   <= 1'b0;
                        state_q <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_ready  = (state_q == IDLE);
    assign m_rvalid = (state_q == RESP);
    assign m_rdata  = rdata_q;
    assign m_err    = err_q;

    // Both ports see the latched address/data; only the selected port gets
    // req and we, so the idle target never observes a write strobe.
    assign s0_req   = (state_q == BUSY) && !sel_q;
    assign s1_req   = (state_q == BUSY) &&  sel_q;
    assign s0_we    = we_q && !sel_q;
    assign s1_we    = we_q &&  sel_q;
    assign s0_addr  = addr_q;
    assign s1_addr  = addr_q;
    assign s0_wdata = wdata_q;
    assign s1_wdata = wdata_q;

endmodule
